// File: rtl/branch_predictor_if.sv
// Fetch-side prediction and execute-side resolution/recovery signals of the branch predictor.
interface branch_predictor_if;
  logic        enable;
  logic [11:0] instr_add;
  logic        is_branch_predict;
  logic [11:0] branch_predict_add;
  logic        resolve_valid;
  logic [11:0] resolve_add;
  logic        resolve_taken;
  logic [11:0] resolve_target;
  logic        resolve_pred_taken;
  logic [11:0] resolve_pred_target;
  logic        is_branch_hazard_stall;
  logic [11:0] branch_hazard_instr_add;
  logic [15:0] mispredict_count;

  modport master (
    output enable, instr_add,
    output resolve_valid, resolve_add, resolve_taken, resolve_target,
    output resolve_pred_taken, resolve_pred_target,
    input  is_branch_predict, branch_predict_add,
    input  is_branch_hazard_stall, branch_hazard_instr_add, mispredict_count
  );

  modport slave (
    input  enable, instr_add,
    input  resolve_valid, resolve_add, resolve_taken, resolve_target,
    input  resolve_pred_taken, resolve_pred_target,
    output is_branch_predict, branch_predict_add,
    output is_branch_hazard_stall, branch_hazard_instr_add, mispredict_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters; predicts fetch redirects and
// raises a held recovery request on a mispredicted branch resolution.
//
// state      | meaning
// ST_IDLE    | no recovery outstanding, resolves are accepted
// ST_PENDING | recovery requested, held until an enabled edge; resolves ignored
module branch_predictor #(
  parameter int ENTRIES = 16
) (
  input  logic              clock,
  input  logic              reset,
  branch_predictor_if.slave bp
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 12 - IDX_W;

  typedef enum logic {ST_IDLE, ST_PENDING} state_t;

  state_t state_q, state_d;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [11:0]        target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  logic [11:0] hazard_add_q;
  logic [15:0] count_q;

  logic [IDX_W-1:0] f_idx, r_idx;
  logic [TAG_W-1:0] f_tag, r_tag;
  logic             f_hit, r_hit;
  logic             accept, mispredict;

  // Lookup reads only the registered table, so a same-cycle update is not visible.
  assign f_idx = bp.instr_add[IDX_W-1:0];
  assign f_tag = bp.instr_add[11:IDX_W];
  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

  assign bp.is_branch_predict  = bp.enable && f_hit && ctr_q[f_idx][1];
  assign bp.branch_predict_add = bp.is_branch_predict ? target_q[f_idx] : 12'h000;

  assign r_idx = bp.resolve_add[IDX_W-1:0];
  assign r_tag = bp.resolve_add[11:IDX_W];
  assign r_hit = valid_q[r_idx] && (tag_q[r_idx] == r_tag);

  assign accept     = bp.resolve_valid && (state_q == ST_IDLE);
  assign mispredict = (bp.resolve_pred_taken != bp.resolve_taken) ||
                      (bp.resolve_pred_taken && bp.resolve_taken &&
                       (bp.resolve_pred_target != bp.resolve_target));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept && mispredict) state_d = ST_PENDING;
      ST_PENDING: if (bp.enable)            state_d = ST_IDLE;
      default:                              state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bp.is_branch_hazard_stall = (state_q == ST_PENDING);
  end

  assign bp.branch_hazard_instr_add = hazard_add_q;
  assign bp.mispredict_count        = count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hazard_add_q <= 12'h000;
      count_q      <= 16'h0000;
    end else if (accept && mispredict) begin
      hazard_add_q <= bp.resolve_taken ? bp.resolve_target : bp.resolve_add + 12'd1;
      if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
    end
  end

  // Taken misses allocate weakly-taken; not-taken misses leave the table alone.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= 12'h000;
        ctr_q[i]    <= 2'b00;
      end
    end else if (accept) begin
      if (r_hit) begin
        if (bp.resolve_taken) begin
          if (ctr_q[r_idx] != 2'b11) ctr_q[r_idx] <= ctr_q[r_idx] + 2'd1;
          target_q[r_idx] <= bp.resolve_target;
        end else if (ctr_q[r_idx] != 2'b00) begin
          ctr_q[r_idx] <= ctr_q[r_idx] - 2'd1;
        end
      end else if (bp.resolve_taken) begin
        valid_q[r_idx]  <= 1'b1;
        tag_q[r_idx]    <= r_tag;
        target_q[r_idx] <= bp.resolve_target;
        ctr_q[r_idx]    <= 2'b10;
      end
    end
  end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Branch target buffer and predictor that sits beside the program counter. It looks up the current fetch address and drives the counter's `is_branch_predict` / `branch_predict_add` redirect inputs. It receives branch resolutions from the execute stage, trains a direct-mapped table of 2-bit saturating counters, and on a misprediction drives the counter's `is_branch_hazard_stall` / `branch_hazard_instr_add` recovery inputs.

## Interface
- `ENTRIES`, 16, number of BTB entries; power of two, 2..256. `IDX_W = log2(ENTRIES)`, `TAG_W = 12 - IDX_W`.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  pipeline advance. Same signal the program counter samples.
- `instr_add`  in  12  current fetch address from the program counter.
- `is_branch_predict`  out  1  predict taken for `instr_add` (combinational).
- `branch_predict_add`  out  12  predicted target. 0 when not predicting.
- `resolve_valid`  in  1  a branch resolved this cycle.
- `resolve_add`  in  12  address of the resolved branch.
- `resolve_taken`  in  1  actual outcome.
- `resolve_target`  in  12  actual taken target.
- `resolve_pred_taken`  in  1  prediction carried down the pipeline for this branch.
- `resolve_pred_target`  in  12  predicted target carried down the pipeline.
- `is_branch_hazard_stall`  out  1  misprediction recovery request (registered, held).
- `branch_hazard_instr_add`  out  12  recovery fetch address (registered).
- `mispredict_count`  out  16  saturating count of mispredictions.

## Operation
- Entry fields: `valid`, `tag[TAG_W]`, `target[12]`, `ctr[2]`.
- Index is `add[IDX_W-1:0]`. Tag is `add[11:IDX_W]`.
- Lookup is combinational on the registered table. No bypass: a same-cycle update is not visible until the next cycle.
- A hit requires the entry to be valid and its tag to equal the address tag.
- `is_branch_predict = enable & hit & ctr[1]`.
- `branch_predict_add` = entry target when `is_branch_predict` is 1, else 0.
- Resolve is accepted when `resolve_valid` is 1 and `pending` is 0. `pending` is the registered `is_branch_hazard_stall`.
- Table update on an accepted resolve, hit at `resolve_add`:
  - Taken: `ctr` saturating increment (max 3); `target <= resolve_target`.
  - Not taken: `ctr` saturating decrement (min 0); target unchanged.
- Table update on an accepted resolve, miss at `resolve_add`:
  - Taken: allocate or replace the entry with valid=1, new tag, `target = resolve_target`, `ctr = 2'b10`.
  - Not taken: no change.
- Mispredict is detected when either holds:
  - `resolve_pred_taken != resolve_taken`;
  - both are taken and `resolve_pred_target != resolve_target`.
- On an accepted mispredict, at the next edge:
  - `is_branch_hazard_stall <= 1`;
  - `branch_hazard_instr_add <= resolve_taken ? resolve_target : resolve_add + 1`. The addition is 12-bit and wraps, so 0xFFF+1 = 0x000.
  - `mispredict_count` increments, saturating at 0xFFFF.
- Pending handshake:
  - `is_branch_hazard_stall` stays high until a rising edge at which `enable` is 1, then clears on that edge.
  - While pending, `resolve_valid` is ignored entirely: no table update, no new mispredict, no count. These resolves are wrong-path branches.
  - `branch_hazard_instr_add` holds its value after the clear.
- `enable` does not gate table updates.

## Timing
- Prediction: zero latency, same cycle as `instr_add`. The program counter loads `branch_predict_add` at the next edge.
- Mispredict: resolve in cycle N produces `is_branch_hazard_stall` high in cycle N+1. It clears at the first edge, at or after the end of cycle N+1, where `enable` is 1.
- Table write takes effect at the edge ending the resolve cycle. A lookup in cycle N+1 sees the new state.
- Reset asserted, asynchronously, at any time:
  - all `valid`, `ctr` and `tag` fields clear; `target` clears to 0;
  - `is_branch_hazard_stall` = 0, `branch_hazard_instr_add` = 0x000, `mispredict_count` = 0;
  - `is_branch_predict` = 0 and `branch_predict_add` = 0 immediately.
  - Reset mid-pending drops the pending request.

## Test plan
- **Reset:** assert reset mid-cycle with `instr_add` = 0x014 -> all outputs 0 immediately. They stay 0 after release while the table is cold.
- **Cold taken branch:** resolve {add 0x014, taken, target 0x080, pred_taken 0} -> next cycle hazard=1 with address 0x080 and count=1. Then `instr_add` = 0x014 with enable=1 -> predict=1, address 0x080.
- **Counter training:**
  - Two not-taken resolves of 0x014 (pred_taken matching each time, so no mispredict) -> `ctr` goes 2->1->0 and predict=0.
  - Then a resolve of 0x014 with pred_taken=1, taken=0 -> hazard address 0x015.
  - Four taken resolves from `ctr` = 0 -> saturates at 3.
- **Wrap:** resolve {add 0xFFF, not taken, pred_taken 1} -> hazard address 0x000.
- **Hold handshake:**
  - Mispredict with enable=0 for 3 cycles -> hazard stays high for 3 cycles and clears after the first enable=1 edge.
  - A resolve issued while pending -> no table change, count unchanged.
- **Alias and same-cycle behaviour (ENTRIES=16):**
  - 0x114 aliases 0x014 (same index, different tag) -> lookup of 0x114 misses.
  - Taken resolve of 0x114 replaces the entry -> 0x014 now misses.
  - Lookup and update of the same index in one cycle -> the lookup returns the old entry.
